mem4c_responder: RTL and testbench

MEM4C_RESPONDER -- requirements
Module: mem4c_responder

---
 rtl/mem4c_responder.sv | 97 +++++++++
 tb/tb_mem4c_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem4c_responder.sv
// mem4c_responder: 2^DEPTH_W x 16-bit memory that answers reads through a fixed four-stage pipeline.
// Optional feature: define MEM4C_OUTSTANDING_EN to add the 3-bit "outstanding" read counter port.
module mem4c_responder #(
   parameter int DEPTH_W = 10,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        data_valid
`ifdef MEM4C_OUTSTANDING_EN
   ,
   output logic [2:0]  outstanding
`endif
);

   logic [15:0]        mem [0:(2**DEPTH_W)-1];
   logic [DEPTH_W-1:0] word_idx;
   logic               rd_acc;
   logic               wr_acc;

   logic               vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
   logic [15:0]        data_p1_q, data_p2_q, data_p3_q, data_p4_q;

   // Byte address: bit 0 and the bits above the word index alias freely.
   // LATENCY is descriptive only; the pipeline below is fixed at four stages.
   logic               unused_ok;
   assign unused_ok = ^{addr[15:DEPTH_W+1], addr[0]} ^ (LATENCY != 4);

   assign word_idx = addr[DEPTH_W:1];
   assign rd_acc   = enable & ~wr;
   assign wr_acc   = enable & wr;

   // Storage is never touched by reset; writes presented during reset are dropped.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[word_idx] <= data_in;
      end
   end

   // Stage p1: capture the addressed word on the accepting edge.
   always_ff @(posedge clk) begin
      data_p1_q <= mem[word_idx];
      // Stages p2..p4: plain shift, no stall.
      data_p2_q <= data_p1_q;
      data_p3_q <= data_p2_q;
      data_p4_q <= data_p3_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         vld_p4_q <= 1'b0;
      end else begin
         vld_p1_q <= rd_acc;
         vld_p2_q <= vld_p1_q;
         vld_p3_q <= vld_p2_q;
         vld_p4_q <= vld_p3_q;
      end
   end

   // Output: data is forced to zero outside the valid pulse, so reset clears it at once.
   assign data_valid = vld_p4_q;
   assign data_out   = vld_p4_q ? data_p4_q : 16'h0000;

`ifdef MEM4C_OUTSTANDING_EN
   logic [2:0] outst_q;
   logic [2:0] outst_d;

   // A return leaves the count in the cycle after its data_valid pulse.
   always_comb begin
      outst_d = outst_q;
      if (rd_acc && !vld_p4_q) begin
         outst_d = outst_q + 3'd1;
      end else if (!rd_acc && vld_p4_q) begin
         outst_d = outst_q - 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outst_q <= 3'd0;
      end else begin
         outst_q <= outst_d;
      end
   end

   assign outstanding = outst_q;
`endif

endmodule

// File: tb/tb_mem4c_responder.sv
// Self-checking bench for mem4c_responder: directed vector table, reset corner cases,
// and randomized traffic checked against a queue-based reference model.
module tb_mem4c_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [15:0] data_in = 16'h0000;
   logic [15:0] data_out;
   logic        data_valid;
`ifdef MEM4C_OUTSTANDING_EN
   logic [2:0]  outstanding;
   int          max_outst = 0;
`endif

   always #5 clk = ~clk;

   mem4c_responder #(.DEPTH_W(10), .LATENCY(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .wr         (wr),
      .addr       (addr),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_valid (data_valid)
`ifdef MEM4C_OUTSTANDING_EN
      ,
      .outstanding(outstanding)
`endif
   );

   typedef struct {
      int          due;
      logic [15:0] data;
   } pend_t;

   typedef struct {
      bit          en;
      bit          w;
      logic [15:0] a;
      logic [15:0] d;
      bit          ev;
      logic [15:0] ed;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   pend_t       pend_q[$];
   logic [15:0] mdl_mem [int];
   logic        smp_valid;
   logic [15:0] smp_data;
   vec_t        tbl [30];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, compare at the falling edge,
   // then let the model absorb the request that the next edge accepts.
   task automatic step(input bit r, input bit en, input bit w,
                       input logic [15:0] a, input logic [15:0] d);
      int    exp_v;
      int    exp_d;
      int    n_out;
      int    idx;
      pend_t p;
      rst = r; enable = en; wr = w; addr = a; data_in = d;
      if (r) pend_q.delete();
      @(negedge clk);
      n_out = pend_q.size();
      exp_v = 0;
      exp_d = 0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
         exp_v = 1;
         exp_d = pend_q[0].data;
         void'(pend_q.pop_front());
      end
      smp_valid = data_valid;
      smp_data  = data_out;
      check("model_valid", data_valid, exp_v);
      check("model_data", data_out, exp_d);
`ifdef MEM4C_OUTSTANDING_EN
      check("model_outstanding", outstanding, n_out);
      if (outstanding > max_outst) max_outst = outstanding;
`else
      if (n_out > 4) check("model_inflight_bound", n_out, 4);
`endif
      if (!r && en) begin
         idx = (int'(a) / 2) % 1024;
         if (w) begin
            mdl_mem[idx] = d;
         end else begin
            p.due  = cyc + 4;
            p.data = mdl_mem[idx];
            pend_q.push_back(p);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      // Directed vectors: each row is one cycle; expected outputs are for that same cycle.
      tbl[0]  = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
      tbl[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      tbl[2]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000};
      tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      tbl[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      tbl[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      tbl[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
      tbl[7]  = '{1'b1, 1'b1, 16'h0000, 16'h1111, 1'b0, 16'h0000};
      tbl[8]  = '{1'b1, 1'b1, 16'h0002, 16'h2222, 1'b0, 16'h0000};
      tbl[9]  = '{1'b1, 1'b1, 16'h0004, 16'h3333, 1'b0, 16'h0000};
      tbl[10] = '{1'b1, 1'b1, 16'h0006, 16'h4444, 1'b0, 16'h0000};
      tbl[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      tbl[12] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0000};
      tbl[13] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h0000};
      tbl[14] = '{1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 16'h0000};
      tbl[15] = '{1'b1, 1'b1, 16'h000A, 16'h0A0A, 1'b1, 16'h1111};
      tbl[16] = '{1'b1, 1'b0, 16'h000A, 16'h0000, 1'b1, 16'h2222};
      tbl[17] = '{1'b1, 1'b1, 16'h000A, 16'h5555, 1'b1, 16'h3333};
      tbl[18] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h4444};
      tbl[19] = '{1'b1, 1'b0, 16'h000A, 16'h0000, 1'b0, 16'h0000};
      tbl[20] = '{1'b1, 1'b0, 16'h0801, 16'h0000, 1'b1, 16'h0A0A};
      tbl[21] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      tbl[22] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      tbl[23] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5555};
      tbl[24] = '{1'b1, 1'b0, 16'h0801, 16'h0000, 1'b1, 16'h1111};
      tbl[25] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      tbl[26] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111};
      tbl[27] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      tbl[28] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111};
      tbl[29] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};

      @(posedge clk);
      #1;
      // Reset state, with a write attempt that must be ignored.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1, 16'h0010, 16'h1234);
         check("reset_valid", smp_valid, 0);
         check("reset_data", smp_data, 0);
      end

      for (int i = 0; i < 30; i++) begin
         step(1'b0, tbl[i].en, tbl[i].w, tbl[i].a, tbl[i].d);
         check("tbl_valid", smp_valid, int'(tbl[i].ev));
         check("tbl_data", smp_data, int'(tbl[i].ed));
      end
`ifdef MEM4C_OUTSTANDING_EN
      check("outstanding_peak", max_outst, 4);
      check("outstanding_idle", outstanding, 0);
`endif

      // Reads in flight are discarded by reset; a write during reset is dropped.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      step(1'b1, 1'b1, 1'b1, 16'h0010, 16'hDEAD);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
         check("flush_valid", smp_valid, 0);
         check("flush_data", smp_data, 0);
      end
      step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      check("post_reset_valid", smp_valid, 1);
      check("post_reset_data", smp_data, 16'hBEEF);

      // Asynchronous reset must kill a pulse already on the output mid-cycle.
      step(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      check("pre_async_valid", data_valid, 1);
      check("pre_async_data", data_out, 16'h2222);
      rst = 1'b1;
      #1;
      check("async_valid", data_valid, 0);
      check("async_data", data_out, 0);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

      // Randomized traffic over eight aliased words.
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b1, 16'(i * 2), 16'($urandom));
      end
      for (int i = 0; i < 600; i++) begin
         logic [15:0] ra;
         ra = {5'($urandom), 7'b0, 3'($urandom), 1'($urandom)};
         step(($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
              ra, 16'($urandom));
      end
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      check("drain_empty", pend_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
